// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use / jr stalls, branch and jump flushes,
// external freeze, and saturating stall/flush event counters.
module hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_JumpReg,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteRegister,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_WriteRegister,
  input  logic             MEM_BranchTaken,
  input  logic             ExtStall,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             Busy
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       ex_nz, mem_nz;
  logic       load_use, jr_ex, jr_mem;
  logic [1:0] need;

  // A destination of r0 never matches anything.
  assign ex_nz  = (EX_WriteRegister != 5'd0);
  assign mem_nz = (MEM_WriteRegister != 5'd0);

  assign load_use = EX_MemRead && ex_nz &&
                    ((EX_WriteRegister == ID_Rs) ||
                     (ID_UsesRt && (EX_WriteRegister == ID_Rt)));
  assign jr_ex    = ID_JumpReg && EX_RegWrite && ex_nz && (EX_WriteRegister == ID_Rs);
  assign jr_mem   = ID_JumpReg && MEM_MemRead && mem_nz && (MEM_WriteRegister == ID_Rs);

  always_comb begin
    need = 2'd0;
    if (load_use || jr_mem || jr_ex) need = 2'd1;
    // jr waiting on a load still in EX needs the value two cycles later.
    if (jr_ex && EX_MemRead) need = 2'd2;
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    state_d     = state_q;
    rem_d       = rem_q;

    if (ExtStall) begin
      // Full freeze: the branch in MEM is held and acted on once released.
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
    end else if (MEM_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      state_d     = RUN;
      rem_d       = 2'd0;
    end else if (state_q == STALL) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      rem_d       = (rem_q == 2'd0) ? 2'd0 : rem_q - 2'd1;
      if (rem_q <= 2'd1) state_d = RUN;
    end else if (need != 2'd0) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      if (need == 2'd2) begin
        state_d = STALL;
        rem_d   = need - 2'd1;
      end
    end else if (ID_Jump) begin
      IFID_Flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (IDEX_Bubble && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (IFID_Flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
  assign Busy       = (state_q == STALL);

endmodule
